// File: rtl/axil_xfer_regs_pkg.sv
// Shared constants, state encodings and helpers for the AXI4-Lite transfer register block.
package axil_xfer_regs_pkg;

    localparam logic [31:0] OFF_CTRL    = 32'h000;
    localparam logic [31:0] OFF_STATUS  = 32'h004;
    localparam logic [31:0] OFF_WR_ADDR = 32'h010;
    localparam logic [31:0] OFF_RD_ADDR = 32'h014;
    localparam logic [31:0] OFF_WDATA0  = 32'h018;
    localparam logic [31:0] OFF_WDATA1  = 32'h01C;
    localparam logic [31:0] OFF_WDATA2  = 32'h020;
    localparam logic [31:0] OFF_WDATA3  = 32'h024;
    localparam logic [31:0] OFF_RDATA0  = 32'h028;
    localparam logic [31:0] OFF_RDATA1  = 32'h02C;
    localparam logic [31:0] OFF_RDATA2  = 32'h030;
    localparam logic [31:0] OFF_RDATA3  = 32'h034;

    localparam int CTRL_START_WR = 0;
    localparam int CTRL_START_RD = 1;
    localparam int STAT_WR_DONE  = 0;
    localparam int STAT_RD_DONE  = 1;
    localparam int STAT_BUSY     = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_HOLD, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_xfer_regs.sv
// AXI4-Lite register block that launches an external 4-word write/read engine and
// reports its completion through sticky status bits.
module axil_xfer_regs
    import axil_xfer_regs_pkg::*;
#(
    parameter int C_DECODE_W = 8,
    parameter int C_ADDR_W   = 32
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [C_ADDR_W-1:0] s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [C_ADDR_W-1:0] s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic                start_wr,
    output logic                start_rd,
    output logic [31:0]         wr_addr,
    output logic [31:0]         rd_addr,
    output logic [127:0]        wdata,
    input  logic                wr_done_i,
    input  logic                rd_done_i,
    input  logic [127:0]        rdata_i,
    output logic                wr_done,
    output logic                rd_done
);

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic                  ready_en_q;
    logic                  aw_held_q, w_held_q;
    logic [C_DECODE_W-1:0] aw_off_q;
    logic [31:0]           wbeat_data_q;
    logic [3:0]            wbeat_strb_q;
    logic [1:0]            bresp_q, bresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic [31:0]           wr_addr_q, rd_addr_q;
    logic [3:0][31:0]      wdat_q, rdat_q;
    logic                  busy_q, wr_done_q, rd_done_q;
    logic                  start_wr_q, start_rd_q;

    logic        aw_hs, w_hs, ar_hs, wr_fire, go_wr, go_rd;
    logic        w_mapped, ctrl_hit, ctrl_bad;
    logic [1:0]  ctrl_bits;
    logic [31:0] woff, roff, status;

    // Upper address bits are deliberately not decoded.
    logic unused_addr;
    assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready = ready_en_q && !aw_held_q && (wr_state_q != WR_RESP);
    assign s_axi_wready  = ready_en_q && !w_held_q && (wr_state_q != WR_RESP);
    assign s_axi_bvalid  = (wr_state_q == WR_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = ready_en_q && (rd_state_q == RD_IDLE);
    assign s_axi_rvalid  = (rd_state_q == RD_RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    assign wr_fire = (wr_state_q == WR_HOLD) && aw_held_q && w_held_q;

    assign start_wr = start_wr_q;
    assign start_rd = start_rd_q;
    assign wr_addr  = wr_addr_q;
    assign rd_addr  = rd_addr_q;
    assign wdata    = wdat_q;
    assign wr_done  = wr_done_q;
    assign rd_done  = rd_done_q;
    assign status   = {29'b0, busy_q, rd_done_q, wr_done_q};

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: if (aw_hs || w_hs) wr_state_d = WR_HOLD;
            WR_HOLD: if (aw_held_q && w_held_q) wr_state_d = WR_RESP;
            WR_RESP: if (s_axi_bready) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (ar_hs) rd_state_d = RD_RESP;
            RD_RESP: if (s_axi_rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Write decode; every mapped offset is word aligned, so misaligned ones fall to default.
    always_comb begin
        woff      = 32'(aw_off_q);
        ctrl_bits = wbeat_data_q[CTRL_START_RD:CTRL_START_WR] & {2{wbeat_strb_q[0]}};
        ctrl_hit  = (woff == OFF_CTRL);
        ctrl_bad  = ctrl_hit && ((ctrl_bits == 2'b11) || ((ctrl_bits != 2'b00) && busy_q));
        go_wr     = wr_fire && ctrl_hit && (ctrl_bits == 2'b01) && !busy_q;
        go_rd     = wr_fire && ctrl_hit && (ctrl_bits == 2'b10) && !busy_q;
        case (woff)
            OFF_CTRL, OFF_STATUS, OFF_WR_ADDR, OFF_RD_ADDR,
            OFF_WDATA0, OFF_WDATA1, OFF_WDATA2, OFF_WDATA3,
            OFF_RDATA0, OFF_RDATA1, OFF_RDATA2, OFF_RDATA3: w_mapped = 1'b1;
            default:                                         w_mapped = 1'b0;
        endcase
        bresp_d = (!w_mapped || ctrl_bad) ? RESP_SLVERR : RESP_OKAY;
    end

    always_comb begin
        roff    = 32'(s_axi_araddr[C_DECODE_W-1:0]);
        rresp_d = RESP_OKAY;
        rdata_d = 32'h0;
        case (roff)
            OFF_CTRL:    rdata_d = 32'h0;
            OFF_STATUS:  rdata_d = status;
            OFF_WR_ADDR: rdata_d = wr_addr_q;
            OFF_RD_ADDR: rdata_d = rd_addr_q;
            OFF_WDATA0:  rdata_d = wdat_q[0];
            OFF_WDATA1:  rdata_d = wdat_q[1];
            OFF_WDATA2:  rdata_d = wdat_q[2];
            OFF_WDATA3:  rdata_d = wdat_q[3];
            OFF_RDATA0:  rdata_d = rdat_q[0];
            OFF_RDATA1:  rdata_d = rdat_q[1];
            OFF_RDATA2:  rdata_d = rdat_q[2];
            OFF_RDATA3:  rdata_d = rdat_q[3];
            default:     rresp_d = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q   <= WR_IDLE;
            rd_state_q   <= RD_IDLE;
            ready_en_q   <= 1'b0;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            aw_off_q     <= '0;
            wbeat_data_q <= 32'h0;
            wbeat_strb_q <= 4'h0;
            bresp_q      <= RESP_OKAY;
            rdata_q      <= 32'h0;
            rresp_q      <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            ready_en_q <= 1'b1;
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_off_q  <= s_axi_awaddr[C_DECODE_W-1:0];
            end
            if (w_hs) begin
                w_held_q     <= 1'b1;
                wbeat_data_q <= s_axi_wdata;
                wbeat_strb_q <= s_axi_wstrb;
            end
            if (wr_fire) bresp_q <= bresp_d;
            if ((wr_state_q == WR_RESP) && s_axi_bready) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end
            if (ar_hs) begin
                rdata_q <= rdata_d;
                rresp_q <= rresp_d;
            end
        end
    end

    // Starts require idle and completions require busy, so the two never collide.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_addr_q  <= 32'h0;
            rd_addr_q  <= 32'h0;
            wdat_q     <= '0;
            rdat_q     <= '0;
            busy_q     <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            start_wr_q <= 1'b0;
            start_rd_q <= 1'b0;
        end else begin
            start_wr_q <= go_wr;
            start_rd_q <= go_rd;
            if (wr_fire) begin
                case (woff)
                    OFF_WR_ADDR: wr_addr_q <= apply_strb(wr_addr_q, wbeat_data_q, wbeat_strb_q);
                    OFF_RD_ADDR: rd_addr_q <= apply_strb(rd_addr_q, wbeat_data_q, wbeat_strb_q);
                    OFF_WDATA0:  wdat_q[0] <= apply_strb(wdat_q[0], wbeat_data_q, wbeat_strb_q);
                    OFF_WDATA1:  wdat_q[1] <= apply_strb(wdat_q[1], wbeat_data_q, wbeat_strb_q);
                    OFF_WDATA2:  wdat_q[2] <= apply_strb(wdat_q[2], wbeat_data_q, wbeat_strb_q);
                    OFF_WDATA3:  wdat_q[3] <= apply_strb(wdat_q[3], wbeat_data_q, wbeat_strb_q);
                    default: ;
                endcase
            end
            if (go_wr) begin
                wr_done_q <= 1'b0;
                busy_q    <= 1'b1;
            end
            if (go_rd) begin
                rd_done_q <= 1'b0;
                busy_q    <= 1'b1;
            end
            if (busy_q && wr_done_i) begin
                wr_done_q <= 1'b1;
                busy_q    <= 1'b0;
            end
            if (busy_q && rd_done_i) begin
                rd_done_q <= 1'b1;
                busy_q    <= 1'b0;
                rdat_q    <= rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_axil_xfer_regs.sv
// Directed self-checking bench for axil_xfer_regs with a response scoreboard.
module tb_axil_xfer_regs;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [31:0]  s_axi_awaddr = 32'h0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata = 32'h0;
    logic [3:0]   s_axi_wstrb = 4'h0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;
    logic [31:0]  s_axi_araddr = 32'h0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;
    logic         start_wr, start_rd;
    logic [31:0]  wr_addr, rd_addr;
    logic [127:0] wdata;
    logic         wr_done_i = 1'b0;
    logic         rd_done_i = 1'b0;
    logic [127:0] rdata_i = 128'h0;
    logic         wr_done, rd_done;

    int checks = 0;
    int failures = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;

    logic [1:0] bq[$];
    rd_exp_t    rq[$];

    localparam logic [127:0] PATTERN = 128'hFEDCBA98_76543210_89ABCDEF_01234567;
    localparam logic [1:0]   OKAY = 2'b00;
    localparam logic [1:0]   SLVERR = 2'b10;

    axil_xfer_regs #(.C_DECODE_W(8), .C_ADDR_W(32)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .start_wr(start_wr), .start_rd(start_rd), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .wdata(wdata), .wr_done_i(wr_done_i), .rd_done_i(rd_done_i), .rdata_i(rdata_i),
        .wr_done(wr_done), .rd_done(rd_done)
    );

    always #5 aclk = ~aclk;

    // Count cycles each start output is high, sampled away from the rising edge.
    always @(negedge aclk) begin
        if (start_wr === 1'b1) wr_pulses++;
        if (start_rd === 1'b1) rd_pulses++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        tick(2);
        chk("rst_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        chk("rst_valids", {s_axi_bvalid, s_axi_rvalid, start_wr, start_rd}, 4'b0000);
        areset = 1'b0;
        tick(1);
        chk("rst_release_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    endtask

    task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er,
                             input int w_lead, input int b_hold);
        int cyc;
        bit aw_done, w_done, aw_go, w_go, stable;
        logic [1:0] resp0, exp_resp;
        bq.push_back(er);
        s_axi_awaddr = a;
        s_axi_wdata = d;
        s_axi_wstrb = s;
        s_axi_wvalid = 1'b1;
        aw_done = 1'b0;
        w_done = 1'b0;
        cyc = 0;
        while (!(aw_done && w_done) && cyc < 64) begin
            if (cyc == w_lead && !aw_done) s_axi_awvalid = 1'b1;
            aw_go = s_axi_awvalid && s_axi_awready;
            w_go = s_axi_wvalid && s_axi_wready;
            tick(1);
            if (aw_go) begin
                s_axi_awvalid = 1'b0;
                aw_done = 1'b1;
            end
            if (w_go) begin
                s_axi_wvalid = 1'b0;
                w_done = 1'b1;
            end
            cyc++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        chk({tag, "_accept"}, {aw_done, w_done}, 2'b11);
        cyc = 0;
        while (!s_axi_bvalid && cyc < 16) begin
            tick(1);
            cyc++;
        end
        resp0 = s_axi_bresp;
        stable = 1'b1;
        for (int i = 0; i < b_hold; i++) begin
            tick(1);
            if (!s_axi_bvalid || s_axi_bresp !== resp0) stable = 1'b0;
        end
        if (b_hold > 0) chk({tag, "_b_stable"}, stable, 1'b1);
        s_axi_bready = 1'b1;
        exp_resp = bq.pop_front();
        chk({tag, "_bresp"}, {s_axi_bvalid, s_axi_bresp}, {1'b1, exp_resp});
        tick(1);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [31:0] a, input logic [31:0] ed,
                            input logic [1:0] er, input int r_hold);
        int cyc;
        bit stable, done;
        logic [33:0] first;
        rd_exp_t e;
        e.data = ed;
        e.resp = er;
        rq.push_back(e);
        s_axi_araddr = a;
        s_axi_arvalid = 1'b1;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 32) begin
            done = s_axi_arready;
            tick(1);
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        s_axi_araddr = 32'hFFFF_FFFF;
        cyc = 0;
        while (!s_axi_rvalid && cyc < 16) begin
            tick(1);
            cyc++;
        end
        first = {s_axi_rresp, s_axi_rdata};
        stable = 1'b1;
        for (int i = 0; i < r_hold; i++) begin
            tick(1);
            if (!s_axi_rvalid || {s_axi_rresp, s_axi_rdata} !== first) stable = 1'b0;
        end
        if (r_hold > 0) chk({tag, "_r_stable"}, stable, 1'b1);
        s_axi_rready = 1'b1;
        e = rq.pop_front();
        chk({tag, "_rdata"}, {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, e.resp, e.data});
        tick(1);
        s_axi_rready = 1'b0;
    endtask

    task automatic pulse_done(input bit is_rd, input logic [127:0] data);
        rdata_i = data;
        if (is_rd) rd_done_i = 1'b1;
        else wr_done_i = 1'b1;
        tick(1);
        rd_done_i = 1'b0;
        wr_done_i = 1'b0;
        tick(1);
    endtask

    initial begin
        int p;
        tick(1);
        do_reset();
        axi_read("status_rst", 32'h004, 32'h0, OKAY, 0);

        // Register file load and readback.
        axi_write("wd0", 32'h018, 32'h01234567, 4'hF, OKAY, 0, 0);
        axi_write("wd1", 32'h01C, 32'h89ABCDEF, 4'hF, OKAY, 0, 0);
        axi_write("wd2", 32'h020, 32'h76543210, 4'hF, OKAY, 0, 0);
        axi_write("wd3", 32'h024, 32'hFEDCBA98, 4'hF, OKAY, 0, 0);
        axi_write("wra", 32'h010, 32'hC0000000, 4'hF, OKAY, 0, 0);
        axi_read("rb_wd0", 32'h018, 32'h01234567, OKAY, 0);
        axi_read("rb_wd1", 32'h01C, 32'h89ABCDEF, OKAY, 0);
        axi_read("rb_wd2", 32'h020, 32'h76543210, OKAY, 0);
        axi_read("rb_wd3", 32'h024, 32'hFEDCBA98, OKAY, 0);
        axi_read("rb_wra", 32'h010, 32'hC0000000, OKAY, 0);
        axi_read("rb_ctrl", 32'h000, 32'h0, OKAY, 0);
        chk("wdata_port", wdata, PATTERN);
        chk("wr_addr_port", wr_addr, 128'hC0000000);

        // Engine write launch, rejected starts while busy, completion.
        p = wr_pulses;
        axi_write("ctrl_wr", 32'h000, 32'h1, 4'hF, OKAY, 0, 0);
        tick(2);
        chk("start_wr_once", wr_pulses - p, 1);
        axi_read("status_busy", 32'h004, 32'h4, OKAY, 0);
        p = wr_pulses + rd_pulses;
        axi_write("ctrl_busy_wr", 32'h000, 32'h1, 4'hF, SLVERR, 0, 0);
        axi_write("ctrl_busy_rd", 32'h000, 32'h2, 4'hF, SLVERR, 0, 0);
        axi_write("wra_busy", 32'h010, 32'hC0000100, 4'hF, OKAY, 0, 0);
        tick(2);
        chk("no_start_busy", wr_pulses + rd_pulses - p, 0);
        chk("wr_addr_busy", wr_addr, 128'hC0000100);
        pulse_done(1'b0, 128'h0);
        axi_read("status_wr_done", 32'h004, 32'h1, OKAY, 0);
        chk("wr_done_port", wr_done, 1'b1);

        do_reset();
        axi_read("status_rst2", 32'h004, 32'h0, OKAY, 0);
        axi_read("wd0_rst2", 32'h018, 32'h0, OKAY, 0);

        // Engine read launch and capture.
        axi_write("rda", 32'h014, 32'hC0000004, 4'hF, OKAY, 0, 0);
        chk("rd_addr_port", rd_addr, 128'hC0000004);
        p = rd_pulses;
        axi_write("ctrl_rd", 32'h000, 32'h2, 4'hF, OKAY, 0, 0);
        tick(2);
        chk("start_rd_once", rd_pulses - p, 1);
        axi_read("status_rd_busy", 32'h004, 32'h4, OKAY, 0);
        pulse_done(1'b1, PATTERN);
        axi_read("rd0", 32'h028, 32'h01234567, OKAY, 0);
        axi_read("rd1", 32'h02C, 32'h89ABCDEF, OKAY, 0);
        axi_read("rd2", 32'h030, 32'h76543210, OKAY, 0);
        axi_read("rd3", 32'h034, 32'hFEDCBA98, OKAY, 0);
        axi_read("status_rd_done", 32'h004, 32'h2, OKAY, 0);
        chk("rd_done_port", {rd_done, wr_done}, 2'b10);

        // Error responses.
        p = wr_pulses + rd_pulses;
        axi_write("ctrl_both", 32'h000, 32'h3, 4'hF, SLVERR, 0, 0);
        axi_write("unmapped_w", 32'h040, 32'h12345678, 4'hF, SLVERR, 0, 0);
        axi_write("misaligned_w", 32'h012, 32'h12345678, 4'hF, SLVERR, 0, 0);
        axi_write("status_ro_w", 32'h004, 32'hFFFFFFFF, 4'hF, OKAY, 0, 0);
        tick(2);
        chk("no_start_err", wr_pulses + rd_pulses - p, 0);
        axi_read("unmapped_r", 32'h040, 32'h0, SLVERR, 0);
        axi_read("status_after_err", 32'h004, 32'h2, OKAY, 0);
        axi_read("upper_ignored", 32'hABCD_0028, 32'h01234567, OKAY, 0);

        // Byte strobes.
        axi_write("strb_wra", 32'h010, 32'hAABBCCDD, 4'b0101, OKAY, 0, 0);
        axi_read("rb_strb", 32'h010, 32'h00BB00DD, OKAY, 0);

        // W leads AW, responses back-pressured.
        axi_write("w_lead", 32'h01C, 32'h5A5A1234, 4'hF, OKAY, 3, 5);
        axi_read("rb_w_lead", 32'h01C, 32'h5A5A1234, OKAY, 5);

        // Done pulses while idle must be ignored.
        pulse_done(1'b1, 128'h0);
        pulse_done(1'b0, 128'h0);
        axi_read("rd0_after_idle_done", 32'h028, 32'h01234567, OKAY, 0);
        axi_read("status_idle_done", 32'h004, 32'h2, OKAY, 0);

        // Reset with a held W beat drops it without a response.
        s_axi_wdata = 32'hDEADBEEF;
        s_axi_wstrb = 4'hF;
        s_axi_wvalid = 1'b1;
        tick(1);
        s_axi_wvalid = 1'b0;
        do_reset();
        tick(3);
        chk("mid_reset_no_b", s_axi_bvalid, 1'b0);
        axi_write("post_rst_w", 32'h020, 32'h0BADF00D, 4'hF, OKAY, 0, 0);
        axi_read("post_rst_r", 32'h020, 32'h0BADF00D, OKAY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_xfer_regs.md
AXIL_XFER_REGS -- requirements
Module: axil_xfer_regs

Interface
REQ-001 Parameter: C_DECODE_W, 8, number of low address bits decoded; upper address bits ignored.
REQ-002 Parameter: C_ADDR_W, 32, AXI4-Lite address width; data width fixed at 32.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 Port: aclk  in  1  sole clock, all logic rising-edge.
REQ-005 Port: areset  in  1  asynchronous active-high reset.
REQ-006 Ports: s_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready  per AXI4-Lite  slave side.
REQ-007 Port: start_wr  out  1  one-cycle pulse launching engine write of WDATA0-3 to WR_ADDR.
REQ-008 Port: start_rd  out  1  one-cycle pulse launching engine read of 4 words from RD_ADDR.
REQ-009 Ports: wr_addr, rd_addr  out  32  contents of WR_ADDR and RD_ADDR registers.
REQ-010 Port: wdata  out  128  {WDATA3,WDATA2,WDATA1,WDATA0}.
REQ-011 Ports: wr_done_i, rd_done_i  in  1  engine completion pulses; rdata_i  in  128  valid with rd_done_i.
REQ-012 Ports: wr_done, rd_done  out  1  sticky completion levels (STATUS[0], STATUS[1]).

Function
REQ-013 Map: 0x000 CTRL (W, reads 0), 0x004 STATUS (RO), 0x010 WR_ADDR, 0x014 RD_ADDR, 0x018-0x024 WDATA0-3 (RW), 0x028-0x034 RDATA0-3 (RO).
REQ-014 Write path: AW and W accepted independently; each ready drops once its beat is held; register update in the cycle after both held; BVALID asserted next cycle, held until BREADY; both readys return high the cycle after B handshake.
REQ-015 WSTRB byte enables honoured on all RW registers.
REQ-016 BRESP: OKAY for mapped offsets including RO (write ignored); SLVERR (2'b10) for unmapped or non-word-aligned offsets.
REQ-017 Read path: ARREADY high while no R pending; RVALID one cycle after AR handshake, RDATA/RRESP stable until RREADY; unmapped read returns 0 with SLVERR.
REQ-018 CTRL write, bit0=1 and bit1=0, not busy: start_wr pulses once, STATUS[0] cleared, STATUS[2] busy set.
REQ-019 CTRL write, bit1=1 and bit0=0, not busy: start_rd pulses once, STATUS[1] cleared, busy set.
REQ-020 CTRL write with both bits set, or any start while busy: no pulse, no state change, BRESP SLVERR.
REQ-021 wr_done_i: sets STATUS[0], clears busy; rd_done_i: sets STATUS[1], captures rdata_i into RDATA0-3, clears busy; done pulses when not busy ignored.
REQ-022 STATUS = {29'b0, busy, rd_done, wr_done}; register write and done pulse in same cycle both take effect.
REQ-023 wr_addr/rd_addr/wdata writes while busy update registers but engine sees values only at next start.

Reset
REQ-024 On areset: all registers, STATUS, RDATA0-3 = 0; awready/wready/arready = 0 during reset, 1 first cycle after release; bvalid/rvalid/start pulses = 0.
REQ-025 Reset mid-transaction drops pending beats and responses without completion.

Structure
REQ-026 Package axil_xfer_regs_pkg holds register offsets, CTRL/STATUS bit indices, RESP_OKAY/RESP_SLVERR constants and write/read FSM state enums (IDLE, HOLD, RESP).
REQ-027 Flat module, no sub-module; engine is external.

Verification
REQ-028 Write 0x01234567,0x89ABCDEF,0x76543210,0xFEDCBA98 to 0x018-0x024, 0xC0000000 to 0x010 -> readback identical, wdata = 0xFEDCBA98_76543210_89ABCDEF_01234567.
REQ-029 Write CTRL=1 -> start_wr single pulse, STATUS=0x4; drive wr_done_i -> STATUS=0x1, wr_done=1.
REQ-030 RD_ADDR=0xC0000004, CTRL=2, rd_done_i with rdata_i pattern above -> RDATA0-3 read back match, STATUS=0x2.
REQ-031 CTRL=1 while busy, CTRL=3, write to 0x040 -> BRESP SLVERR each, no start pulse; read 0x040 -> 0, SLVERR.
REQ-032 W before AW by 3 cycles, BREADY/RREADY held low 5 cycles -> correct update, BVALID/RVALID and data stable throughout.
